// File: rtl/rv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit:
// funct3 opcodes and the controller state encoding.
package rv_pkg;

   localparam logic [2:0] MDU_OPC_MUL    = 3'd0;
   localparam logic [2:0] MDU_OPC_MULH   = 3'd1;
   localparam logic [2:0] MDU_OPC_MULHSU = 3'd2;
   localparam logic [2:0] MDU_OPC_MULHU  = 3'd3;
   localparam logic [2:0] MDU_OPC_DIV    = 3'd4;
   localparam logic [2:0] MDU_OPC_DIVU   = 3'd5;
   localparam logic [2:0] MDU_OPC_REM    = 3'd6;
   localparam logic [2:0] MDU_OPC_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

endpackage

// File: rtl/rv_muldiv_step.sv
// One iteration on unsigned magnitudes: LSB-first shift-add for multiply,
// or one restoring-subtract step for divide. {i_hi,i_lo} is the accumulator pair.
module rv_muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_hi,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_op,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0] w_sum;
   logic [XLEN:0] w_rem;
   logic          w_ge;

   assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_op} : {(XLEN+1){1'b0}});
   assign w_rem = {i_hi, i_lo[XLEN-1]};
   assign w_ge  = (w_rem >= {1'b0, i_op});

   // When the subtract succeeds the partial remainder is below the divisor, so XLEN bits hold it
   always_comb begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
      if (i_is_div) begin
         o_hi = w_ge ? (w_rem[XLEN-1:0] - i_op) : w_rem[XLEN-1:0];
         o_lo = {i_lo[XLEN-2:0], w_ge};
      end
   end

endmodule

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes,
// single-cycle divide-by-zero / overflow fast path and result hold in DONE.
//
// state | meaning
// IDLE  | ready to accept an operation
// CALC  | BITS_PER_CYCLE steps per cycle on latched magnitudes
// FIX   | sign correction and result selection
// DONE  | result valid, waiting for out_ready
module rv_muldiv
   import rv_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_opc,
   input  logic [XLEN-1:0] in_op1,
   input  logic [XLEN-1:0] in_op2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result
);

   localparam int ITER = XLEN / BITS_PER_CYCLE;
   localparam int CW   = $clog2(ITER + 1);

   mdu_state_e      r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_opc;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_op;
   logic            r_neg_q;
   logic            r_neg_r;
   logic [XLEN-1:0] r_result;
   logic            r_out_valid;

   logic            w_is_div, w_s1, w_s2, w_neg1, w_neg2;
   logic            w_div0, w_ovf, w_fast;
   logic [XLEN-1:0] w_mag1, w_mag2, w_fast_res;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0] w_quo, w_rem, w_fix_res;

   logic [XLEN-1:0] w_hi [BITS_PER_CYCLE+1];
   logic [XLEN-1:0] w_lo [BITS_PER_CYCLE+1];

   assign in_ready   = (r_state == ST_IDLE);
   assign out_valid  = r_out_valid;
   assign out_result = r_result;

   assign w_is_div = in_opc[2];
   assign w_s1     = (in_opc != MDU_OPC_MULHU) && (in_opc != MDU_OPC_DIVU) && (in_opc != MDU_OPC_REMU);
   assign w_s2     = (in_opc == MDU_OPC_MUL) || (in_opc == MDU_OPC_MULH) ||
                     (in_opc == MDU_OPC_DIV) || (in_opc == MDU_OPC_REM);
   assign w_neg1   = w_s1 & in_op1[XLEN-1];
   assign w_neg2   = w_s2 & in_op2[XLEN-1];
   assign w_mag1   = w_neg1 ? -in_op1 : in_op1;
   assign w_mag2   = w_neg2 ? -in_op2 : in_op2;

   assign w_div0 = w_is_div && (in_op2 == '0);
   assign w_ovf  = ((in_opc == MDU_OPC_DIV) || (in_opc == MDU_OPC_REM)) &&
                   (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_op2 == '1);
   assign w_fast = w_div0 || w_ovf;
   // in_opc[1] distinguishes remainder from quotient among the divide opcodes
   assign w_fast_res = w_div0 ? (in_opc[1] ? in_op1 : '1)
                              : (in_opc[1] ? '0 : in_op1);

   assign w_hi[0] = r_hi;
   assign w_lo[0] = r_lo;

   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
      rv_muldiv_step #(.XLEN(XLEN)) u_step (
         .i_is_div (r_opc[2]),
         .i_hi     (w_hi[g]),
         .i_lo     (w_lo[g]),
         .i_op     (r_op),
         .o_hi     (w_hi[g+1]),
         .o_lo     (w_lo[g+1])
      );
   end

   assign w_prod_s = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
   assign w_quo    = r_neg_q ? -r_lo : r_lo;
   assign w_rem    = r_neg_r ? -r_hi : r_hi;

   always_comb begin
      w_fix_res = w_rem;
      case (r_opc)
         MDU_OPC_MUL:                              w_fix_res = w_prod_s[XLEN-1:0];
         MDU_OPC_MULH, MDU_OPC_MULHSU, MDU_OPC_MULHU: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
         MDU_OPC_DIV, MDU_OPC_DIVU:                w_fix_res = w_quo;
         default:                                  w_fix_res = w_rem;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_opc       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_op        <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (w_fast) begin
                     r_result    <= w_fast_res;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_opc   <= in_opc;
                     r_hi    <= '0;
                     r_lo    <= w_is_div ? w_mag1 : w_mag2;
                     r_op    <= w_is_div ? w_mag2 : w_mag1;
                     r_neg_q <= w_neg1 ^ w_neg2;
                     r_neg_r <= w_neg1;
                     r_cnt   <= CW'(ITER);
                     r_state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               r_hi  <= w_hi[BITS_PER_CYCLE];
               r_lo  <= w_lo[BITS_PER_CYCLE];
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) r_state <= ST_FIX;
            end
            ST_FIX: begin
               r_result    <= w_fix_res;
               r_out_valid <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_muldiv.sv
// Self-checking bench: two rv_muldiv instances (1 and 4 bits per cycle) driven in lockstep,
// checked against an arithmetic reference of the RV32M rules.
module tb_rv_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, out_ready;
   logic [2:0]  in_opc;
   logic [31:0] in_op1, in_op2;

   logic        in_ready1, out_valid1, in_ready4, out_valid4;
   logic [31:0] out_result1, out_result4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rv_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_opc(in_opc),
      .in_op1(in_op1), .in_op2(in_op2), .flush(flush), .out_valid(out_valid1),
      .out_ready(out_ready), .out_result(out_result1)
   );

   rv_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_opc(in_opc),
      .in_op1(in_op1), .in_op2(in_op2), .flush(flush), .out_valid(out_valid4),
      .out_ready(out_ready), .out_result(out_result4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mdu(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (opc)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
      return opc[2] && ((b == 0) ||
             ((opc == 3'd4 || opc == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Called one time unit after a rising edge with both units idle
   task automatic run_op(input string tag, input logic [2:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
      int lat1, lat4;
      bit fast;
      fast = is_fast(opc, a, b);
      check({tag, "_rdy"}, {63'b0, in_ready1 & in_ready4}, 64'd1);
      in_valid = 1'b1; in_opc = opc; in_op1 = a; in_op2 = b;
      @(posedge clk); #1;
      in_valid = 1'b0; in_opc = 3'($urandom); in_op1 = $urandom; in_op2 = $urandom;
      lat1 = -1; lat4 = -1;
      for (int c = 0; c < 60; c++) begin
         if (out_valid1 && lat1 < 0) lat1 = c;
         if (out_valid4 && lat4 < 0) lat4 = c;
         if (lat1 >= 0 && lat4 >= 0) break;
         @(posedge clk); #1;
      end
      check({tag, "_lat1"}, 64'(lat1), fast ? 64'd0 : 64'd33);
      check({tag, "_lat4"}, 64'(lat4), fast ? 64'd0 : 64'd9);
      check({tag, "_res1"}, {32'b0, out_result1}, {32'b0, exp});
      check({tag, "_res4"}, {32'b0, out_result4}, {32'b0, exp});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_v"}, {63'b0, out_valid1 & out_valid4}, 64'd1);
         check({tag, "_hold_r"}, {32'b0, out_result1}, {32'b0, exp});
         check({tag, "_hold_rdy"}, {63'b0, in_ready1 | in_ready4}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_drain"}, {62'b0, out_valid1, out_valid4}, 64'd0);
      check({tag, "_idle"}, {62'b0, in_ready1, in_ready4}, 64'd3);
   endtask

   task automatic watch_no_valid(input string tag, input int cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (out_valid1 || out_valid4) seen = 1'b1;
      end
      check(tag, {63'b0, seen}, 64'd0);
   endtask

   initial begin
      logic [2:0]  r_opc;
      logic [31:0] r_a, r_b;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_opc = '0; in_op1 = '0; in_op2 = '0;
      #23;
      check("reset_rdy", {62'b0, in_ready1, in_ready4}, 64'd3);
      check("reset_vld", {62'b0, out_valid1, out_valid4}, 64'd0);
      check("reset_res", {out_result1, out_result4}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 10);
      run_op("mulh",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
      run_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      run_op("div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
      run_op("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
      run_op("divu",      3'd5, 32'd7,          32'd2,         32'd3,         0);
      run_op("remu",      3'd7, 32'd7,          32'd2,         32'd1,         0);
      run_op("divu_z",    3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2);
      run_op("rem_z",     3'd6, 32'd5,          32'd0,         32'd5,         0);
      run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
      run_op("divu_wide", 3'd5, 32'd100,        32'd7,         32'd14,        0);

      // flush wins over a simultaneous accept
      in_valid = 1'b1; flush = 1'b1; in_opc = 3'd5; in_op1 = 32'd100; in_op2 = 32'd7;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_acc_rdy", {62'b0, in_ready1, in_ready4}, 64'd3);
      watch_no_valid("flush_acc_novld", 40);

      // flush mid-calculation
      in_valid = 1'b1; in_opc = 3'd0; in_op1 = 32'd1234; in_op2 = 32'd5678;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_calc_rdy", {62'b0, in_ready1, in_ready4}, 64'd3);
      check("flush_calc_vld", {62'b0, out_valid1, out_valid4}, 64'd0);
      watch_no_valid("flush_calc_novld", 50);

      for (int k = 0; k < 60; k++) begin
         r_opc = 3'($urandom);
         case ($urandom_range(0, 5))
            0:       r_a = 32'h8000_0000;
            1:       r_a = 32'hFFFF_FFFF;
            default: r_a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       r_b = 32'h0;
            1:       r_b = 32'hFFFF_FFFF;
            2:       r_b = 32'($urandom_range(1, 20));
            default: r_b = $urandom;
         endcase
         run_op("rand", r_opc, r_a, r_b, ref_mdu(r_opc, r_a, r_b), $urandom_range(0, 3));
      end

      // asynchronous reset mid-calculation after a nonzero result has been held
      run_op("pre_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
      in_valid = 1'b1; in_opc = 3'd4; in_op1 = 32'd999; in_op2 = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_rdy", {62'b0, in_ready1, in_ready4}, 64'd3);
      check("rst_mid_vld", {62'b0, out_valid1, out_valid4}, 64'd0);
      check("rst_mid_res", {out_result1, out_result4}, 64'd0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      run_op("post_rst", 3'd7, 32'd100, 32'd7, 32'd2, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
